// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and RISC-V opcode constants for the perf window controller
package perf_pkg;

    typedef enum logic [2:0] {
        REC_CYCLES  = 3'd0,
        REC_RETIRED = 3'd1,
        REC_ALU     = 3'd2,
        REC_LOAD    = 3'd3,
        REC_STORE   = 3'd4,
        REC_BRANCH  = 3'd5
    } rec_id_e;

    typedef enum logic {
        RUN_IDLE = 1'b0,
        RUN_RUN  = 1'b1
    } run_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_SEND = 1'b1
    } drain_state_e;

    localparam int REC_COUNT = 6;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/perf_instr_classify.sv
// rtl/perf_instr_classify.sv - retire qualification and one-hot instruction class decode
module perf_instr_classify
    import perf_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic        qual_i,
    output logic        retire_o,
    output logic [3:0]  class_o
);

    logic retire;

    // class_o is {alu, load, store, branch}; all zero for unlisted opcodes
    always_comb begin
        retire  = qual_i && (instr_i != NOP_INSTR);
        class_o = 4'b0000;
        if (retire) begin
            case (instr_i[6:0])
                OP_REG, OP_IMM, OP_AUIPC, OP_LUI: class_o = 4'b1000;
                OP_LOAD:                          class_o = 4'b0100;
                OP_STORE:                         class_o = 4'b0010;
                OP_BRANCH, OP_JAL, OP_JALR:       class_o = 4'b0001;
                default:                          class_o = 4'b0000;
            endcase
        end
        retire_o = retire;
    end

endmodule

// File: rtl/perf_window_ctrl.sv
// rtl/perf_window_ctrl.sv - windowed retired-instruction counters with double-buffered record drain
module perf_window_ctrl
    import perf_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             valid_wb_i,
    input  logic             stall_wb_i,
    input  logic [31:0]      instr_wb_i,
    output logic             rec_valid_o,
    input  logic             rec_ready_i,
    output rec_id_e          rec_id_o,
    output logic [CNT_W-1:0] rec_data_o,
    output logic             rec_last_o,
    output logic [15:0]      window_idx_o,
    output logic             busy_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [2:0]       LAST_REC = 3'(REC_COUNT - 1);

    logic       retire;
    logic [3:0] cls;

    perf_instr_classify u_classify (
        .instr_i  (instr_wb_i),
        .qual_i   (valid_wb_i & ~stall_wb_i),
        .retire_o (retire),
        .class_o  (cls)
    );

    run_state_e       run_q, run_d;
    drain_state_e     drain_q, drain_d;
    logic [CNT_W-1:0] live_q   [REC_COUNT];
    logic [CNT_W-1:0] live_d   [REC_COUNT];
    logic [CNT_W-1:0] live_inc [REC_COUNT];
    logic [CNT_W-1:0] shadow_q [REC_COUNT];
    logic [CNT_W-1:0] shadow_d [REC_COUNT];
    logic [2:0]       rec_idx_q, rec_idx_d;
    logic [15:0]      win_idx_q, win_idx_d;
    logic             ovf_q, ovf_d;
    logic [REC_COUNT-1:0] event_vec;
    logic             window_close;
    logic             handshake;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        // bit order follows rec_id_e so the shadow bank indexes directly by record id
        event_vec = {cls[0], cls[1], cls[2], cls[3], retire, 1'b1};
        for (int i = 0; i < REC_COUNT; i++) begin
            live_inc[i] = sat_inc(live_q[i], event_vec[i]);
        end

        window_close = (run_q == RUN_RUN) && !stop_i && (live_q[0] == LAST_CYC);
        handshake    = (drain_q == D_SEND) && rec_ready_i;

        run_d     = run_q;
        drain_d   = drain_q;
        live_d    = live_q;
        shadow_d  = shadow_q;
        rec_idx_d = rec_idx_q;
        win_idx_d = win_idx_q;
        ovf_d     = ovf_q;

        case (run_q)
            RUN_IDLE: begin
                if (start_i && !stop_i) begin
                    run_d = RUN_RUN;
                    for (int i = 0; i < REC_COUNT; i++) live_d[i] = '0;
                end
            end
            RUN_RUN: begin
                if (stop_i) begin
                    run_d = RUN_IDLE;
                end else if (window_close) begin
                    for (int i = 0; i < REC_COUNT; i++) live_d[i] = '0;
                end else begin
                    live_d = live_inc;
                end
            end
            default: run_d = RUN_IDLE;
        endcase

        if (handshake) begin
            if (rec_idx_q == LAST_REC) begin
                drain_d   = D_IDLE;
                rec_idx_d = 3'd0;
            end else begin
                rec_idx_d = rec_idx_q + 3'd1;
            end
        end

        // a close while the previous snapshot is still draining loses the new one
        if (window_close) begin
            if (drain_q == D_IDLE) begin
                shadow_d  = live_inc;
                win_idx_d = win_idx_q + 16'd1;
                drain_d   = D_SEND;
                rec_idx_d = 3'd0;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            run_q     <= RUN_IDLE;
            drain_q   <= D_IDLE;
            rec_idx_q <= 3'd0;
            win_idx_q <= 16'd0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < REC_COUNT; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            run_q     <= run_d;
            drain_q   <= drain_d;
            rec_idx_q <= rec_idx_d;
            win_idx_q <= win_idx_d;
            ovf_q     <= ovf_d;
            live_q    <= live_d;
            shadow_q  <= shadow_d;
        end
    end

    always_comb begin
        rec_valid_o  = (drain_q == D_SEND);
        rec_id_o     = rec_valid_o ? rec_id_e'(rec_idx_q) : REC_CYCLES;
        rec_data_o   = rec_valid_o ? shadow_q[rec_idx_q] : '0;
        rec_last_o   = rec_valid_o && (rec_idx_q == LAST_REC);
        window_idx_o = win_idx_q;
        busy_o       = (run_q == RUN_RUN);
        overflow_o   = ovf_q;
    end

endmodule

// File: tb/tb_perf_window_ctrl.sv
// tb/tb_perf_window_ctrl.sv - self-checking bench for perf_window_ctrl
module tb_perf_window_ctrl;
    import perf_pkg::*;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic        valid_wb = 1'b0, stall_wb = 1'b0;
    logic [31:0] instr_wb = 32'h0;
    logic        rec_ready = 1'b0;
    logic        rec_valid;
    rec_id_e     rec_id;
    logic [31:0] rec_data;
    logic        rec_last;
    logic [15:0] win_idx;
    logic        busy;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    perf_window_ctrl #(.WINDOW_CYCLES(W), .CNT_W(32)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .start_i      (start),
        .stop_i       (stop),
        .valid_wb_i   (valid_wb),
        .stall_wb_i   (stall_wb),
        .instr_wb_i   (instr_wb),
        .rec_valid_o  (rec_valid),
        .rec_ready_i  (rec_ready),
        .rec_id_o     (rec_id),
        .rec_data_o   (rec_data),
        .rec_last_o   (rec_last),
        .window_idx_o (win_idx),
        .busy_o       (busy),
        .overflow_o   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: queue of pending records ----------------
    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        logic        last;
    } rec_t;

    rec_t            mq[$];
    bit              m_run = 1'b0;
    bit              m_ovf = 1'b0;
    logic [15:0]     m_widx = 16'd0;
    longint unsigned m_cnt[6];
    bit              m_was_busy;
    int              m_k;

    function automatic int classify(input logic [31:0] ins);
        case (ins[6:0])
            7'h33, 7'h13, 7'h17, 7'h37: return 2;
            7'h03:                      return 3;
            7'h23:                      return 4;
            7'h63, 7'h6f, 7'h67:        return 5;
            default:                    return 1;
        endcase
    endfunction

    function automatic longint unsigned bump(input longint unsigned v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 1'b0;
            m_ovf = 1'b0;
            m_widx = 16'd0;
            mq.delete();
            for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        end else begin
            m_was_busy = (mq.size() != 0);
            if (m_was_busy && rec_ready) void'(mq.pop_front());
            if (m_run) begin
                if (stop) begin
                    m_run = 1'b0;
                end else begin
                    m_cnt[0] = bump(m_cnt[0]);
                    if (valid_wb && !stall_wb && instr_wb != 32'h13) begin
                        m_cnt[1] = bump(m_cnt[1]);
                        m_k = classify(instr_wb);
                        if (m_k >= 2) m_cnt[m_k] = bump(m_cnt[m_k]);
                    end
                    if (m_cnt[0] == W) begin
                        if (!m_was_busy) begin
                            for (int i = 0; i < 6; i++)
                                mq.push_back('{id: 3'(i), data: 32'(m_cnt[i]), last: (i == 5)});
                            m_widx = m_widx + 16'd1;
                        end else begin
                            m_ovf = 1'b1;
                        end
                        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
                    end
                end
            end else if (start && !stop) begin
                m_run = 1'b1;
                for (int i = 0; i < 6; i++) m_cnt[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_valid", rec_valid, (mq.size() != 0));
            check("mon_busy", busy, m_run);
            check("mon_ovf", ovf, m_ovf);
            check("mon_widx", win_idx, m_widx);
            if (mq.size() != 0) begin
                check("mon_id", 32'(rec_id), 32'(mq[0].id));
                check("mon_data", rec_data, mq[0].data);
                check("mon_last", rec_last, mq[0].last);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; valid_wb = 1'b0; stall_wb = 1'b0; instr_wb = 32'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        rec_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 100 && !rec_valid; n++) tick();
        check({tag, "_wait_valid"}, rec_valid, 1'b1);
    endtask

    task automatic settle();
        rec_ready = 1'b1;
        pulse_stop();
        for (int n = 0; n < 20 && rec_valid; n++) tick();
        check("settle_idle", rec_valid, 1'b0);
    endtask

    task automatic drain_expect(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3,
                                input logic [31:0] e4, input logic [31:0] e5);
        logic [31:0] e[6];
        e = '{e0, e1, e2, e3, e4, e5};
        wait_valid(tag);
        rec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check({tag, "_valid"}, rec_valid, 1'b1);
            check({tag, "_id"}, 32'(rec_id), i);
            check({tag, "_data"}, rec_data, e[i]);
            check({tag, "_last"}, rec_last, (i == 5));
            tick();
        end
        check({tag, "_done"}, rec_valid, 1'b0);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        stall;
        logic [31:0] retired, alu, load, store, branch;
    } vec_t;

    vec_t vecs[13];
    bit   seen;

    initial begin
        vecs[0]  = '{32'h002081b3, 1, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{32'h00108093, 1, 0, 1, 1, 0, 0, 0};
        vecs[2]  = '{32'h000000b7, 1, 0, 1, 1, 0, 0, 0};
        vecs[3]  = '{32'h00000097, 1, 0, 1, 1, 0, 0, 0};
        vecs[4]  = '{32'h0000a103, 1, 0, 1, 0, 1, 0, 0};
        vecs[5]  = '{32'h0020a023, 1, 0, 1, 0, 0, 1, 0};
        vecs[6]  = '{32'h00000063, 1, 0, 1, 0, 0, 0, 1};
        vecs[7]  = '{32'h0000006f, 1, 0, 1, 0, 0, 0, 1};
        vecs[8]  = '{32'h000080e7, 1, 0, 1, 0, 0, 0, 1};
        vecs[9]  = '{32'h0000000f, 1, 0, 1, 0, 0, 0, 0};
        vecs[10] = '{32'h00000013, 1, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{32'h00108093, 1, 1, 0, 0, 0, 0, 0};
        vecs[12] = '{32'h00108093, 0, 0, 0, 0, 0, 0, 0};

        // reset state
        tick();
        tick();
        mon_en = 1'b1;
        check("rst_valid", rec_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_widx", win_idx, 16'd0);
        check("rst_id", 32'(rec_id), 0);
        check("rst_data", rec_data, 32'd0);
        check("rst_last", rec_last, 1'b0);
        reset_n = 1'b1;
        tick();

        // mixed window: 5 ADDI, 2 LW, 1 SW, 1 BEQ
        rec_ready = 1'b1;
        pulse_start();
        check("start_busy", busy, 1'b1);
        valid_wb = 1'b1;
        for (int i = 0; i < 9; i++) begin
            instr_wb = (i < 5) ? 32'h00108093 : (i < 7) ? 32'h0000a103 :
                       (i < 8) ? 32'h0020a023 : 32'h00000063;
            tick();
        end
        valid_wb = 1'b0;
        drain_expect("mix", 16, 9, 5, 2, 1, 1);
        check("mix_widx", win_idx, 16'd1);
        settle();

        // single-instruction classification table
        for (int v = 0; v < 13; v++) begin
            pulse_start();
            instr_wb = vecs[v].instr; valid_wb = vecs[v].valid; stall_wb = vecs[v].stall;
            tick();
            idle_inputs();
            drain_expect($sformatf("vec%0d", v), 16, vecs[v].retired, vecs[v].alu,
                         vecs[v].load, vecs[v].store, vecs[v].branch);
            settle();
        end

        // held record under backpressure, second close dropped
        do_reset();
        rec_ready = 1'b0;
        pulse_start();
        wait_valid("ovf");
        check("ovf_first_widx", win_idx, 16'd1);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("hold_valid", rec_valid, 1'b1);
            check("hold_id", 32'(rec_id), 0);
            check("hold_data", rec_data, 32'd16);
        end
        check("ovf_set", ovf, 1'b1);
        check("ovf_widx", win_idx, 16'd1);
        drain_expect("ovf_drain", 16, 0, 0, 0, 0, 0);
        settle();
        check("ovf_sticky", ovf, 1'b1);

        // stop mid-window discards it; restart counts from zero
        do_reset();
        pulse_start();
        repeat (5) tick();
        pulse_stop();
        check("stop_busy", busy, 1'b0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (rec_valid) seen = 1'b1;
        end
        check("stop_no_rec", seen, 1'b0);
        pulse_start();
        drain_expect("restart", 16, 0, 0, 0, 0, 0);
        settle();

        // start and stop together from idle
        do_reset();
        start = 1'b1; stop = 1'b1;
        tick();
        idle_inputs();
        check("both_busy", busy, 1'b0);
        repeat (20) tick();
        check("both_busy_later", busy, 1'b0);
        check("both_no_rec", rec_valid, 1'b0);

        // async reset while record 3 is presented
        do_reset();
        pulse_start();
        wait_valid("rstmid");
        repeat (3) tick();
        check("rstmid_id", 32'(rec_id), 3);
        reset_n = 1'b0;
        #1;
        check("rstmid_valid", rec_valid, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ovf", ovf, 1'b0);
        check("rstmid_widx", win_idx, 16'd0);
        check("rstmid_data", rec_data, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check("rstmid_after", rec_valid, 1'b0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 29) == 0);
            stop      = ($urandom_range(0, 149) == 0);
            valid_wb  = $urandom_range(0, 1);
            stall_wb  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: instr_wb = 32'h00000013;
                1: instr_wb = 32'h0000a103;
                2: instr_wb = 32'h0020a023;
                3: instr_wb = 32'h00000063;
                4: instr_wb = 32'h002081b3;
                default: instr_wb = $urandom();
            endcase
            rec_ready = ((c % 200) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
